// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage 16-bit pipeline. Each cycle
// it decides whether the PC and each pipeline register loads, holds or loads
// a bubble, and it sequences the HALT drain (RUN -> DRAIN -> HALTED).
// Optional performance counters are built only when PIPE_PERF_CNT_EN is
// defined; otherwise stall_cycles/flush_count are tied to zero.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs_addr,
    input  logic        id_rs_used,
    input  logic [2:0]  id_rt_addr,
    input  logic        id_rt_used,
    input  logic        id_halt,
    input  logic [2:0]  ex_wr_addr,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_bubble,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0] drain_cnt_nxt;
    logic             halted_q;
    logic             luh;

    // A load in EX whose destination feeds the ID instruction needs one bubble.
    assign luh = ex_mem_read & ex_reg_write &
                 ((id_rs_used & (id_rs_addr == ex_wr_addr)) |
                  (id_rt_used & (id_rt_addr == ex_wr_addr)));

    // Next-state and enable decode; everything is forced to 0 while rst is low.
    always_comb begin
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_en       = 1'b0;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b0;
        memwb_en      = 1'b0;
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        if (rst) begin
            case (state)
                RUN: begin
                    if (dmem_stall) begin
                        // whole pipeline frozen, defaults already hold it
                    end else if (branch_taken) begin
                        // ID instruction is squashed, so luh/halt/imem are moot
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (luh) begin
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (imem_stall) begin
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (id_halt) begin
                        // HALT moves on to EX; nothing younger may follow it
                        ifid_en       = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_en       = 1'b1;
                        exmem_en      = 1'b1;
                        memwb_en      = 1'b1;
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_LOAD;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                DRAIN: begin
                    if (!dmem_stall) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        if (drain_cnt <= CNT_ONE) begin
                            drain_cnt_nxt = '0;
                            state_nxt     = HALTED;
                        end else begin
                            drain_cnt_nxt = drain_cnt - CNT_ONE;
                        end
                    end
                end
                HALTED: begin
                    // stopped until reset
                end
                default: begin
                    state_nxt     = RUN;
                    drain_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, drain counter and registered halted flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            halted_q  <= (state_nxt == HALTED);
        end
    end

    assign halted = halted_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;
    logic        flush_by_branch;

    assign flush_by_branch = (state == RUN) & branch_taken & ifid_flush;

    // Saturating counters of PC-stall cycles and branch-induced flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state != HALTED) && !pc_en && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
            if (flush_by_branch && (flush_q != 16'hFFFF))
                flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs_addr, id_rt_addr, ex_wr_addr;
    logic        id_rs_used, id_rt_used, id_halt;
    logic        ex_reg_write, ex_mem_read;
    logic        branch_taken, imem_stall, dmem_stall;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic        exmem_en, memwb_en, halted;
    logic [15:0] stall_cycles, flush_count;
    logic [6:0]  ctrl_obs;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: 0 = running, 1 = draining, 2 = halted
    int          m_mode;
    int          m_left;
    int unsigned m_stall;
    int unsigned m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
        .id_halt(id_halt), .ex_wr_addr(ex_wr_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .imem_stall(imem_stall),
        .dmem_stall(dmem_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctrl_obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_luh();
        return ex_mem_read && ex_reg_write &&
               ((id_rs_used && id_rs_addr == ex_wr_addr) ||
                (id_rt_used && id_rt_addr == ex_wr_addr));
    endfunction

    // Expected {pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb}
    function automatic logic [6:0] model_ctrl();
        if (m_mode == 0) begin
            if (dmem_stall)                return 7'b0000000;
            if (branch_taken)              return 7'b1111111;
            if (model_luh())               return 7'b0001111;
            if (imem_stall || id_halt)     return 7'b0111011;
            return 7'b1101011;
        end
        if (m_mode == 1) return dmem_stall ? 7'b0000000 : 7'b0111011;
        return 7'b0000000;
    endfunction

    task automatic clear_inputs();
        id_rs_addr = 3'd0; id_rt_addr = 3'd0; ex_wr_addr = 3'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_halt = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    endtask

    task automatic set_luh();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_wr_addr = 3'd3;
        id_rs_addr = 3'd3; id_rs_used = 1'b1;
    endtask

    // Called just after a falling edge with inputs applied: check, clock, advance model.
    task automatic tick();
        logic pc_stalled;
        logic [15:0] exp_stall, exp_flush;
        #1;
        chk("ctrl", {9'd0, ctrl_obs}, {9'd0, model_ctrl()});
        chk("halted", 16'(halted), (m_mode == 2) ? 16'd1 : 16'd0);
`ifdef PIPE_PERF_CNT_EN
        exp_stall = 16'(m_stall);
        exp_flush = 16'(m_flush);
`else
        exp_stall = 16'd0;
        exp_flush = 16'd0;
`endif
        chk("stall_cycles", stall_cycles, exp_stall);
        chk("flush_count", flush_count, exp_flush);
        @(posedge clk);
        if (m_mode == 0) begin
            pc_stalled = dmem_stall || (!branch_taken && (model_luh() || imem_stall || id_halt));
            if (pc_stalled && m_stall < 65535) m_stall++;
            if (!dmem_stall && branch_taken && m_flush < 65535) m_flush++;
            if (!dmem_stall && !branch_taken && !model_luh() && !imem_stall && id_halt) begin
                m_mode = 1;
                m_left = DRAIN;
            end
        end else if (m_mode == 1) begin
            if (m_stall < 65535) m_stall++;
            if (!dmem_stall) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse started mid-cycle; outputs must clear without an edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_ctrl", {9'd0, ctrl_obs}, 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_stall_cycles", stall_cycles, 16'd0);
        chk("rst_flush_count", flush_count, 16'd0);
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        do_reset();

        // first cycle after reset release: free-running
        #1 chk("first_pc_en", 16'(pc_en), 16'd1);
        tick();

        // load-use on rs: one bubble cycle, then flow resumes
        set_luh();
        #1 chk("lu_pc_en", 16'(pc_en), 16'd0);
        chk("lu_ifid_en", 16'(ifid_en), 16'd0);
        chk("lu_bubble", 16'(idex_bubble), 16'd1);
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        #1 chk("lu_after_pc_en", 16'(pc_en), 16'd1);
        chk("lu_after_ifid_en", 16'(ifid_en), 16'd1);
        tick();
        clear_inputs();

        // branch beats load-use and halt in the same cycle
        set_luh(); branch_taken = 1'b1; id_halt = 1'b1;
        #1 chk("br_flush", 16'(ifid_flush), 16'd1);
        chk("br_bubble", 16'(idex_bubble), 16'd1);
        chk("br_pc_en", 16'(pc_en), 16'd1);
        tick();
        clear_inputs();
        repeat (5) begin
            #1 chk("br_no_halt", 16'(halted), 16'd0);
            tick();
        end

        // data-memory stall over a load-use: 4 frozen cycles, then the bubble
        set_luh(); dmem_stall = 1'b1;
        repeat (4) begin
            #1 chk("ds_frozen", {9'd0, ctrl_obs}, 16'd0);
            tick();
        end
        dmem_stall = 1'b0;
        #1 chk("ds_bubble", {9'd0, ctrl_obs}, 16'h000F);
        tick();
        clear_inputs();
        tick();

        // halt drain without stalls: halted at N+DRAIN+1
        id_halt = 1'b1;
        tick();
        clear_inputs();
        repeat (DRAIN) begin
            #1 chk("drain_not_halted", 16'(halted), 16'd0);
            tick();
        end
        #1 chk("drain_halted", 16'(halted), 16'd1);
        chk("halted_ctrl", {9'd0, ctrl_obs}, 16'd0);
        tick();
        tick();
        do_reset();

        // halt drain with two data-memory stall cycles: halted at N+6
        id_halt = 1'b1;
        tick();
        clear_inputs();
        tick();
        dmem_stall = 1'b1;
        tick();
        tick();
        dmem_stall = 1'b0;
        repeat (2) begin
            #1 chk("drain_ds_not_halted", 16'(halted), 16'd0);
            tick();
        end
        #1 chk("drain_ds_halted", 16'(halted), 16'd1);
        tick();

        // reset in the middle of a drain
        do_reset();
        id_halt = 1'b1;
        tick();
        clear_inputs();
        tick();
        do_reset();
        #1 chk("post_rst_pc_en", 16'(pc_en), 16'd1);
        tick();

        // performance counters: 3 branch flushes, 2 load-use stalls
        do_reset();
        repeat (3) begin
            branch_taken = 1'b1;
            tick();
            branch_taken = 1'b0;
            tick();
        end
        repeat (2) begin
            set_luh();
            tick();
            clear_inputs();
            tick();
        end
        #1;
`ifdef PIPE_PERF_CNT_EN
        chk("perf_flush", flush_count, 16'd3);
        chk("perf_stall", stall_cycles, 16'd2);
`else
        chk("perf_flush_off", flush_count, 16'd0);
        chk("perf_stall_off", stall_cycles, 16'd0);
`endif
        tick();

        // randomized traffic
        repeat (600) begin
            id_rs_addr   = 3'($urandom_range(0, 3));
            id_rt_addr   = 3'($urandom_range(0, 3));
            ex_wr_addr   = 3'($urandom_range(0, 3));
            id_rs_used   = 1'($urandom_range(0, 1));
            id_rt_used   = 1'($urandom_range(0, 1));
            ex_reg_write = ($urandom_range(0, 3) != 0);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            imem_stall   = ($urandom_range(0, 5) == 0);
            dmem_stall   = ($urandom_range(0, 7) == 0);
            id_halt      = ($urandom_range(0, 9) == 0);
            tick();
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
                do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
